// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcode constants, the canonical NOP encoding
// and the immediate-format selector used by the decode stage.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // ADDI x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_sel_t;

endpackage

// File: rtl/regfile.sv
// 32x32 integer register file: two asynchronous read ports, one synchronous
// write port, asynchronous active-high reset. x0 always reads 0.
// Optional macro WB_BYPASS_EN: a read of the register being written this
// cycle returns the incoming write data (write-first).
module regfile
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic        we,
    input  logic [4:0]  rd,
    input  logic [31:0] wdata
);

    logic [31:0] regs [32];

    // Storage: cleared on reset, x0 is never written so it stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (rd != 5'd0)) begin
            regs[rd] <= wdata;
        end
    end

    // Read ports: x0 forced to zero, optional same-cycle writeback bypass.
    always_comb begin
        rs1_data = regs[rs1];
        rs2_data = regs[rs2];
`ifdef WB_BYPASS_EN
        if (we && (rd != 5'd0) && (rd == rs1)) begin
            rs1_data = wdata;
        end
        if (we && (rd != 5'd0) && (rd == rs2)) begin
            rs2_data = wdata;
        end
`endif
        if (rs1 == 5'd0) begin
            rs1_data = '0;
        end
        if (rs2 == 5'd0) begin
            rs2_data = '0;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// RV32I decode stage plus ID/EX pipeline register. Decodes fields and
// immediates, reads the register file, detects load-use hazards and stalls
// fetch/IF-ID for one cycle while inserting a bubble.
// Optional macro WB_BYPASS_EN selects write-first register-file reads.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     nextinst,
    input  logic [XLEN-1:0] nextPC,
    input  logic            ex_flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            PCWrite,
    output logic            IFIDWrite,
    output logic            idex_valid,
    output logic [XLEN-1:0] idex_pc,
    output logic [XLEN-1:0] idex_rs1_data,
    output logic [XLEN-1:0] idex_rs2_data,
    output logic [XLEN-1:0] idex_imm,
    output logic [4:0]      idex_rs1,
    output logic [4:0]      idex_rs2,
    output logic [4:0]      idex_rd,
    output logic [6:0]      idex_opcode,
    output logic [2:0]      idex_funct3,
    output logic            idex_funct7b5,
    output logic            idex_memread,
    output logic            idex_memwrite,
    output logic            idex_regwrite
);

    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    imm_sel_t        imm_sel;
    logic            memread;
    logic            memwrite;
    logic            writes_rd;
    logic            regwrite;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            hazard;
    logic            stall;

    assign opcode   = nextinst[6:0];
    assign rd       = nextinst[11:7];
    assign funct3   = nextinst[14:12];
    assign rs1      = nextinst[19:15];
    assign rs2      = nextinst[24:20];
    assign funct7b5 = nextinst[30];

    regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rs1      (rs1),
        .rs2      (rs2),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .we       (wb_we),
        .rd       (wb_rd),
        .wdata    (wb_data)
    );

    // Opcode decode: immediate format, memory controls and register usage.
    always_comb begin
        imm_sel   = IMM_NONE;
        memread   = 1'b0;
        memwrite  = 1'b0;
        writes_rd = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        case (opcode)
            OPC_LOAD: begin
                imm_sel   = IMM_I;
                memread   = 1'b1;
                writes_rd = 1'b1;
                uses_rs1  = 1'b1;
            end
            OPC_STORE: begin
                imm_sel  = IMM_S;
                memwrite = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_BRANCH: begin
                imm_sel  = IMM_B;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_JALR: begin
                imm_sel   = IMM_I;
                writes_rd = 1'b1;
                uses_rs1  = 1'b1;
            end
            OPC_JAL: begin
                imm_sel   = IMM_J;
                writes_rd = 1'b1;
            end
            OPC_OP_IMM: begin
                imm_sel   = IMM_I;
                writes_rd = 1'b1;
                uses_rs1  = 1'b1;
            end
            OPC_OP: begin
                writes_rd = 1'b1;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm_sel   = IMM_U;
                writes_rd = 1'b1;
            end
            default: begin
                imm_sel = IMM_NONE;
            end
        endcase
    end

    assign regwrite = writes_rd & (rd != 5'd0);

    // Immediate generation, all formats sign-extended from bit 31.
    always_comb begin
        imm = '0;
        case (imm_sel)
            IMM_I: imm = {{20{nextinst[31]}}, nextinst[31:20]};
            IMM_S: imm = {{20{nextinst[31]}}, nextinst[31:25], nextinst[11:7]};
            IMM_B: imm = {{19{nextinst[31]}}, nextinst[31], nextinst[7],
                          nextinst[30:25], nextinst[11:8], 1'b0};
            IMM_U: imm = {nextinst[31:12], 12'b0};
            IMM_J: imm = {{11{nextinst[31]}}, nextinst[31], nextinst[19:12],
                          nextinst[20], nextinst[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    // A load in EX whose destination feeds this instruction must be waited
    // for; a taken branch in EX squashes ID anyway, so it overrides the stall.
    assign hazard = idex_valid & idex_memread & (idex_rd != 5'd0) &
                    ((uses_rs1 & (rs1 == idex_rd)) | (uses_rs2 & (rs2 == idex_rd)));
    assign stall     = hazard & ~ex_flush;
    assign PCWrite   = ~stall;
    assign IFIDWrite = ~stall;

    // ID/EX register: bubble on flush or stall, otherwise the decoded instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || 1'b0) begin
            idex_valid    <= 1'b0;
            idex_pc       <= '0;
            idex_rs1_data <= '0;
            idex_rs2_data <= '0;
            idex_imm      <= '0;
            idex_rs1      <= '0;
            idex_rs2      <= '0;
            idex_rd       <= '0;
            idex_opcode   <= '0;
            idex_funct3   <= '0;
            idex_funct7b5 <= 1'b0;
            idex_memread  <= 1'b0;
            idex_memwrite <= 1'b0;
            idex_regwrite <= 1'b0;
        end else if (ex_flush || stall) begin
            idex_valid    <= 1'b0;
            idex_pc       <= '0;
            idex_rs1_data <= '0;
            idex_rs2_data <= '0;
            idex_imm      <= '0;
            idex_rs1      <= '0;
            idex_rs2      <= '0;
            idex_rd       <= '0;
            idex_opcode   <= '0;
            idex_funct3   <= '0;
            idex_funct7b5 <= 1'b0;
            idex_memread  <= 1'b0;
            idex_memwrite <= 1'b0;
            idex_regwrite <= 1'b0;
        end else begin
            idex_valid    <= 1'b1;
            idex_pc       <= nextPC;
            idex_rs1_data <= rs1_data;
            idex_rs2_data <= rs2_data;
            idex_imm      <= imm;
            idex_rs1      <= rs1;
            idex_rs2      <= rs2;
            idex_rd       <= rd;
            idex_opcode   <= opcode;
            idex_funct3   <= funct3;
            idex_funct7b5 <= funct7b5;
            idex_memread  <= memread;
            idex_memwrite <= memwrite;
            idex_regwrite <= regwrite;
        end
    end

endmodule
